snake_move_scheduler: RTL and testbench



---
 rtl/snake_pkg.sv | 22 ++
 rtl/snake_move_scheduler_tick_gen.sv | 29 ++
 rtl/snake_move_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the three-snake LED lane scheduler.
// Snake A has length 1, B has length 2, C has length 3.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    localparam int L_A = 1;
    localparam int L_B = 2;
    localparam int L_C = 3;

    localparam int OFF_A0 = 15;
    localparam int OFF_B0 = 10;
    localparam int OFF_C0 = 0;

endpackage

// File: rtl/snake_move_scheduler_tick_gen.sv
// Clock-enable tick generator: one-cycle pulse every PER enabled cycles.
// The counter freezes while en is low, so no tick is produced then.
module tick_gen
    import snake_pkg::*;
#(
    parameter int PER = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (PER > 1) ? $clog2(PER) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(PER - 1));

    // Count enabled cycles and wrap on the tick cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/snake_move_scheduler.sv
// Round-robin move scheduler for three snakes sharing one LED lane.
// Each granted move is wall/collision checked against committed state.
module snake_move_scheduler
    import snake_pkg::*;
#(
    parameter int W     = 16,
    parameter int PER_A = 16777216,
    parameter int PER_B = 33554432,
    parameter int PER_C = 67108864
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] led,
    output logic         busy,
    output logic [2:0]   grant,
    output logic [2:0]   dir,
    output logic [2:0]   overrun
);

    localparam int OW = $clog2(W);

    function automatic logic [1:0] len_of(input int k);
        return (k == 0) ? 2'(L_A) : (k == 1) ? 2'(L_B) : 2'(L_C);
    endfunction

    function automatic logic [W-1:0] mask_of(
        input logic [OW-1:0] o,
        input logic [1:0]    len
    );
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m << o;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    win_q, win_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [OW-1:0] cand_q, cand_d;
    logic          cdir_q, cdir_d;
    logic [2:0]    pend_q;
    logic [2:0]    tick;
    logic [OW-1:0] off_q [3];

    logic          pick_ok;
    logic [1:0]    pick_idx;
    logic [OW-1:0] win_off;
    logic          win_dir;
    logic [1:0]    win_len;
    logic [OW-1:0] lim;
    logic [W-1:0]  others;
    logic          blocked;

    tick_gen #(.PER(PER_A)) u_tick_a (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick[0])
    );

    tick_gen #(.PER(PER_B)) u_tick_b (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick[1])
    );

    tick_gen #(.PER(PER_C)) u_tick_c (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick[2])
    );

    // First pending snake scanning ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        logic [2:0] s;
        pick_ok  = 1'b0;
        pick_idx = ptr_q;
        s        = '0;
        for (int i = 2; i >= 0; i--) begin
            s = {1'b0, ptr_q} + 3'(i);
            if (s > 3'd2) s = s - 3'd3;
            if (pend_q[s[1:0]]) begin
                pick_ok  = 1'b1;
                pick_idx = s[1:0];
            end
        end
    end

    // Winner's state, its wall limit and the mask of the other two snakes.
    always_comb begin
        win_off = '0;
        win_dir = 1'b0;
        win_len = 2'd1;
        others  = '0;
        for (int i = 0; i < 3; i++) begin
            if (win_q == 2'(i)) begin
                win_off = off_q[i];
                win_dir = dir[i];
                win_len = len_of(i);
            end else begin
                others = others | mask_of(off_q[i], len_of(i));
            end
        end
        lim     = OW'(W - int'(win_len));
        blocked = |(mask_of(cand_q, win_len) & others);
    end

    // Candidate step, reversing at either wall.
    always_comb begin
        cand_d = cand_q;
        cdir_d = cdir_q;
        if (state_q == CALC) begin
            if (win_dir == DIR_LEFT) begin
                if (win_off < lim) begin
                    cand_d = win_off + OW'(1);
                    cdir_d = DIR_LEFT;
                end else begin
                    cand_d = win_off - OW'(1);
                    cdir_d = DIR_RIGHT;
                end
            end else begin
                if (win_off != '0) begin
                    cand_d = win_off - OW'(1);
                    cdir_d = DIR_RIGHT;
                end else begin
                    cand_d = win_off + OW'(1);
                    cdir_d = DIR_LEFT;
                end
            end
        end
    end

    // Next-state and grant decode for the IDLE/CALC/COMMIT sequence.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        grant   = '0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (en && pick_ok) begin
                    win_d   = pick_idx;
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = COMMIT;
            end
            COMMIT: begin
                grant   = 3'b001 << win_q;
                ptr_d   = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            cand_q  <= '0;
            cdir_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cand_q  <= cand_d;
            cdir_q  <= cdir_d;
        end
    end

    // Pending requests; a tick landing on its own commit is a fresh request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= '0;
            overrun <= '0;
        end else begin
            pend_q  <= (pend_q & ~grant) | tick;
            overrun <= overrun | (tick & pend_q & ~grant);
        end
    end

    // Commit the winner's move, or turn it around when blocked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_q[0] <= OW'(OFF_A0);
            off_q[1] <= OW'(OFF_B0);
            off_q[2] <= OW'(OFF_C0);
            dir      <= {DIR_LEFT, DIR_RIGHT, DIR_RIGHT};
        end else if (state_q == COMMIT) begin
            for (int i = 0; i < 3; i++) begin
                if (win_q == 2'(i)) begin
                    if (!blocked) begin
                        off_q[i] <= cand_q;
                        dir[i]   <= cdir_q;
                    end else begin
                        dir[i]   <= ~cdir_q;
                    end
                end
            end
        end
    end

    // Lane image from the committed offsets.
    always_comb begin
        led = '0;
        for (int i = 0; i < 3; i++) begin
            led = led | mask_of(off_q[i], len_of(i));
        end
    end

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench for snake_move_scheduler: four DUT copies with different
// tick periods, checked against a scoreboard fed by a small lane model.
module tb_snake_move_scheduler;

    typedef struct packed {
        logic [2:0]  g;
        logic [15:0] led;
        logic [2:0]  d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst_i;
    logic [3:0]       en_i;
    logic [3:0][15:0] led_o;
    logic [3:0]       busy_o;
    logic [3:0][2:0]  grant_o;
    logic [3:0][2:0]  dir_o;
    logic [3:0][2:0]  ovr_o;

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;

    exp_t sbq[$];
    int   mo[3];
    logic [2:0] md;

    always @(posedge clk) cyc <= cyc + 1;

    snake_move_scheduler #(.W(16), .PER_A(4), .PER_B(1000), .PER_C(1000)) u0 (
        .clk(clk), .rst(rst_i[0]), .en(en_i[0]), .led(led_o[0]),
        .busy(busy_o[0]), .grant(grant_o[0]), .dir(dir_o[0]),
        .overrun(ovr_o[0])
    );

    snake_move_scheduler #(.W(16), .PER_A(1000), .PER_B(1000), .PER_C(4)) u1 (
        .clk(clk), .rst(rst_i[1]), .en(en_i[1]), .led(led_o[1]),
        .busy(busy_o[1]), .grant(grant_o[1]), .dir(dir_o[1]),
        .overrun(ovr_o[1])
    );

    snake_move_scheduler #(.W(16), .PER_A(9), .PER_B(9), .PER_C(9)) u2 (
        .clk(clk), .rst(rst_i[2]), .en(en_i[2]), .led(led_o[2]),
        .busy(busy_o[2]), .grant(grant_o[2]), .dir(dir_o[2]),
        .overrun(ovr_o[2])
    );

    snake_move_scheduler #(.W(16), .PER_A(2), .PER_B(1000), .PER_C(1000)) u3 (
        .clk(clk), .rst(rst_i[3]), .en(en_i[3]), .led(led_o[3]),
        .busy(busy_o[3]), .grant(grant_o[3]), .dir(dir_o[3]),
        .overrun(ovr_o[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mmask(input int o, input int len);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < len; i++) begin
            if (o + i < 16) m[o+i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [15:0] model_led();
        return mmask(mo[0], 1) | mmask(mo[1], 2) | mmask(mo[2], 3);
    endfunction

    task automatic model_reset();
        mo[0] = 15;
        mo[1] = 10;
        mo[2] = 0;
        md    = 3'b100;
        sbq.delete();
    endtask

    task automatic model_push(input int k);
        int          len;
        int          cand;
        logic        cd;
        logic [15:0] oth;
        exp_t        e;
        len = k + 1;
        if (md[k]) begin
            if (mo[k] < 16 - len) begin cand = mo[k] + 1; cd = 1'b1; end
            else begin cand = mo[k] - 1; cd = 1'b0; end
        end else begin
            if (mo[k] > 0) begin cand = mo[k] - 1; cd = 1'b0; end
            else begin cand = mo[k] + 1; cd = 1'b1; end
        end
        oth = '0;
        for (int j = 0; j < 3; j++) begin
            if (j != k) oth = oth | mmask(mo[j], j + 1);
        end
        if ((mmask(cand, len) & oth) == 16'h0) begin
            mo[k] = cand;
            md[k] = cd;
        end else begin
            md[k] = ~cd;
        end
        e.g   = 3'(1 << k);
        e.led = model_led();
        e.d   = md;
        sbq.push_back(e);
    endtask

    task automatic wait_grant(input int u, output bit ok, output int gc);
        ok = 1'b0;
        gc = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (grant_o[u] != 3'b000) begin
                ok = 1'b1;
                gc = cyc;
                break;
            end
        end
        if (!ok) begin
            vec++;
            miss++;
            $error("FAIL timeout u%0d: observed no grant, expected one", u);
        end
    endtask

    task automatic check_next(input int u, output int gc);
        exp_t e;
        bit   ok;
        wait_grant(u, ok, gc);
        if (sbq.size() == 0) begin
            vec++;
            miss++;
            $error("FAIL sb_empty u%0d: observed grant, expected none", u);
            return;
        end
        e = sbq.pop_front();
        if (!ok) return;
        chk("grant", 32'(grant_o[u]), 32'(e.g));
        chk("busy", 32'(busy_o[u]), 32'd1);
        @(negedge clk);
        chk("led", 32'(led_o[u]), 32'(e.led));
        chk("dir", 32'(dir_o[u]), 32'(e.d));
    endtask

    initial begin
        int  t0;
        int  gc;
        int  g[6];
        bit  ok;

        rst_i = 4'b0000;
        en_i  = 4'b1001;
        repeat (3) @(negedge clk);

        for (int u = 0; u < 4; u++) begin
            chk("rst_led", 32'(led_o[u]), 32'h8C07);
            chk("rst_busy", 32'(busy_o[u]), 32'd0);
            chk("rst_grant", 32'(grant_o[u]), 32'd0);
            chk("rst_ovr", 32'(ovr_o[u]), 32'd0);
        end

        model_reset();
        for (int i = 0; i < 5; i++) model_push(0);
        rst_i[0] = 1'b1;
        t0 = cyc;
        repeat (2) @(negedge clk);
        chk("a_hold_led", 32'(led_o[0]), 32'h8C07);
        check_next(0, gc);
        chk("a_latency", 32'(gc - t0), 32'd6);
        chk("a_first_led", 32'(led_o[0]), 32'h4C07);
        check_next(0, gc);
        check_next(0, gc);
        chk("a_at12_led", 32'(led_o[0]), 32'h1C07);
        check_next(0, gc);
        chk("a_block_led", 32'(led_o[0]), 32'h1C07);
        chk("a_block_dir", 32'(dir_o[0][0]), 32'd1);
        check_next(0, gc);
        chk("a_back_led", 32'(led_o[0]), 32'h2C07);
        en_i[0] = 1'b0;

        model_reset();
        for (int i = 0; i < 16; i++) model_push(2);
        rst_i[1] = 1'b1;
        en_i[1]  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_next(1, gc);
            if (i == 6) chk("c_at7_led", 32'(led_o[1]), 32'h8F80);
            if (i == 7) begin
                chk("c_block_led", 32'(led_o[1]), 32'h8F80);
                chk("c_block_dir", 32'(dir_o[1][2]), 32'd0);
            end
            if (i == 15) begin
                chk("c_wall_led", 32'(led_o[1]), 32'h8C0E);
                chk("c_wall_dir", 32'(dir_o[1][2]), 32'd1);
            end
        end
        en_i[1] = 1'b0;

        model_reset();
        for (int r = 0; r < 2; r++) begin
            model_push(0);
            model_push(1);
            model_push(2);
        end
        rst_i[2] = 1'b1;
        en_i[2]  = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            check_next(2, gc);
            g[i] = gc;
        end
        chk("sim_lat", 32'(g[0] - t0), 32'd11);
        chk("sim_gap_b", 32'(g[1] - g[0]), 32'd3);
        chk("sim_gap_c", 32'(g[2] - g[1]), 32'd3);
        chk("sim_round2", 32'(g[3] - t0), 32'd20);
        chk("sim_ovr", 32'(ovr_o[2]), 32'd0);
        en_i[2] = 1'b0;

        rst_i[3] = 1'b1;
        wait_grant(3, ok, gc);
        chk("ovr_grant1", 32'(grant_o[3]), 32'b001);
        chk("ovr_set", 32'(ovr_o[3]), 32'b001);
        wait_grant(3, ok, gc);
        chk("ovr_grant2", 32'(grant_o[3]), 32'b001);
        chk("ovr_led_pre", 32'(led_o[3]), 32'h4C07);
        #1;
        rst_i[3] = 1'b0;
        #1;
        chk("ovr_rst_led", 32'(led_o[3]), 32'h8C07);
        chk("ovr_rst_ovr", 32'(ovr_o[3]), 32'd0);
        chk("ovr_rst_busy", 32'(busy_o[3]), 32'd0);
        chk("ovr_rst_grant", 32'(grant_o[3]), 32'd0);
        repeat (2) @(negedge clk);
        chk("ovr_rst_hold", 32'(led_o[3]), 32'h8C07);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
